// File: rtl/vga_frame_buffer_pkg.sv
// VGA 640x480@60 timing constants and the shared coordinate type for the
// frame buffer block.
package vga_pkg;

   typedef logic [9:0] coord_t;

   localparam coord_t H_ACTIVE   = 10'd640;
   localparam coord_t H_FP       = 10'd16;
   localparam coord_t H_SYNC     = 10'd96;
   localparam coord_t H_BP       = 10'd48;
   localparam coord_t H_TOTAL    = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 10'd1);
   localparam coord_t H_SYNC_BEG = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_SYNC_END = coord_t'(H_SYNC_BEG + H_SYNC);

   localparam coord_t V_ACTIVE   = 10'd480;
   localparam coord_t V_FP       = 10'd10;
   localparam coord_t V_SYNC     = 10'd2;
   localparam coord_t V_BP       = 10'd33;
   localparam coord_t V_TOTAL    = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 10'd1);
   localparam coord_t V_SYNC_BEG = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_SYNC_END = coord_t'(V_SYNC_BEG + V_SYNC);

endpackage

// File: rtl/vga_frame_buffer_if.sv
// Pixel-stream input and VGA output bundle of the frame buffer; the frame
// buffer is the slave, the pixel source / display side is the master.
interface vga_frame_buffer_if;

   logic [7:0] pixel_i;
   logic       pixel_en_i;
   logic       frame_clr_i;
   logic       frame_done_o;
   logic       frame_valid_o;
   logic       hsync_o;
   logic       vsync_o;
   logic [3:0] vga_r_o;
   logic [3:0] vga_g_o;
   logic [3:0] vga_b_o;

   modport slave (
      input  pixel_i, pixel_en_i, frame_clr_i,
      output frame_done_o, frame_valid_o, hsync_o, vsync_o,
      output vga_r_o, vga_g_o, vga_b_o
   );

   modport master (
      output pixel_i, pixel_en_i, frame_clr_i,
      input  frame_done_o, frame_valid_o, hsync_o, vsync_o,
      input  vga_r_o, vga_g_o, vga_b_o
   );

endinterface

// File: rtl/vga_frame_buffer_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port,
// read-first when both ports hit the same address in one cycle.
module frame_ram #(
   parameter int DEPTH  = 291600,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/vga_frame_buffer.sv
// Raster-order frame store fed by the pixel stream, scanned out with
// 640x480@60 VGA timing as 4-bit grayscale on all three colour channels.
module vga_frame_buffer
   import vga_pkg::*;
#(
   parameter int IMG_W   = 540,
   parameter int IMG_H   = 540,
   parameter int ADDR_W  = 19,
   parameter int PIX_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_frame_buffer_if.slave bus
);

   localparam int                DIV_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PIX_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);
   localparam coord_t            IMG_W_C   = coord_t'(IMG_W);
   localparam coord_t            IMG_H_C   = coord_t'(IMG_H);

   logic [DIV_W-1:0]  div_q, div_d;
   coord_t            h_q, h_d;
   coord_t            v_q, v_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_valid_q, frame_valid_d;
   logic              hs_s1_q, hs_s1_d;
   logic              vs_s1_q, vs_s1_d;
   logic              win_s1_q, win_s1_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic [3:0]        rgb_q, rgb_d;

   logic              pix_tick;
   logic              wr_last;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic [3:0]        rd_lsb_unused;

   frame_ram #(
      .DEPTH  (IMG_W * IMG_H),
      .ADDR_W (ADDR_W),
      .DATA_W (8)
   ) u_frame_ram (
      .clk   (clk),
      .we    (bus.pixel_en_i),
      .waddr (wr_addr_q),
      .wdata (bus.pixel_i),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign rd_lsb_unused = rd_data[3:0];

   // Counters and line base move only on the pixel tick.
   always_comb begin
      pix_tick    = (div_q == DIV_LAST);
      div_d       = pix_tick ? '0 : div_q + 1'b1;
      h_d         = h_q;
      v_d         = v_q;
      line_base_d = line_base_q;
      if (pix_tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d         = '0;
               line_base_d = '0;
            end else begin
               v_d = v_q + 1'b1;
               if (v_q < IMG_H_C) begin
                  line_base_d = line_base_q + LINE_STEP;
               end
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Clear overrides the increment but the coincident pixel still lands at the old address.
   always_comb begin
      wr_last   = (wr_addr_q == LAST_ADDR);
      wr_addr_d = wr_addr_q;
      if (bus.pixel_en_i) begin
         wr_addr_d = wr_last ? '0 : wr_addr_q + 1'b1;
      end
      if (bus.frame_clr_i) begin
         wr_addr_d = '0;
      end
      frame_done_d  = bus.pixel_en_i && wr_last;
      frame_valid_d = frame_valid_q || frame_done_d;
   end

   always_comb begin
      rd_addr  = line_base_q + ADDR_W'(h_q);
      win_s1_d = (h_q < IMG_W_C) && (h_q < H_ACTIVE) &&
                 (v_q < IMG_H_C) && (v_q < V_ACTIVE);
      hs_s1_d  = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
      vs_s1_d  = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
      hsync_d  = hs_s1_q;
      vsync_d  = vs_s1_q;
      rgb_d    = (win_s1_q && frame_valid_q) ? rd_data[7:4] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         line_base_q   <= '0;
         wr_addr_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         hs_s1_q       <= 1'b1;
         vs_s1_q       <= 1'b1;
         win_s1_q      <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= '0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         line_base_q   <= line_base_d;
         wr_addr_q     <= wr_addr_d;
         frame_done_q  <= frame_done_d;
         frame_valid_q <= frame_valid_d;
         hs_s1_q       <= hs_s1_d;
         vs_s1_q       <= vs_s1_d;
         win_s1_q      <= win_s1_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
      end
   end

   assign bus.frame_done_o  = frame_done_q;
   assign bus.frame_valid_o = frame_valid_q;
   assign bus.hsync_o       = hsync_q;
   assign bus.vsync_o       = vsync_q;
   assign bus.vga_r_o       = rgb_q;
   assign bus.vga_g_o       = rgb_q;
   assign bus.vga_b_o       = rgb_q;

endmodule
